decode_stage: RTL

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/cpu_pkg.sv | 64 ++++++
 rtl/imm_gen.sv | 29 ++
 rtl/decode_stage.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared decode definitions: opcodes, alu_op encoding, bubble word
// and the decode-to-execute bundle.
package cpu_pkg;

    localparam logic [31:0] NOP_INST = 32'h00000013;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_PASSB  = 5'd10,
        ALU_MUL    = 5'd11,
        ALU_MULH   = 5'd12,
        ALU_MULHSU = 5'd13,
        ALU_MULHU  = 5'd14,
        ALU_DIV    = 5'd15,
        ALU_DIVU   = 5'd16,
        ALU_REM    = 5'd17,
        ALU_REMU   = 5'd18
    } alu_op_e;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } fmt_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] imm;
        alu_op_e     alu_op;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        illegal;
    } id_ex_t;

endpackage

// File: rtl/imm_gen.sv
// Immediate extraction for RV32I instruction formats.
// R-type (and anything without an immediate) yields zero.
module imm_gen
    import cpu_pkg::*;
(
    input  logic [31:0] inst,
    input  fmt_e        fmt,
    output logic [31:0] imm
);

    logic unused_opc;
    assign unused_opc = ^inst[6:0];

    // Sign-extend the immediate fields of the selected format
    always_comb begin
        imm = '0;
        unique case (fmt)
            FMT_I: imm = {{20{inst[31]}}, inst[31:20]};
            FMT_S: imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B: imm = {{19{inst[31]}}, inst[31], inst[7],
                          inst[30:25], inst[11:8], 1'b0};
            FMT_U: imm = {inst[31:12], 12'b0};
            FMT_J: imm = {{11{inst[31]}}, inst[31], inst[19:12],
                          inst[20], inst[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage with load-use interlock, flush and hold.
// Define DECODE_RV32M_EN to decode the RV32M multiply/divide ops.
module decode_stage #(
    parameter logic [31:0] NOP_INST = cpu_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inst_valid,
    input  logic [31:0] inst,
    input  logic [31:0] pc_in,
    input  logic        stall_in,
    input  logic        flush,
    output logic [4:0]  rs1i,
    output logic [4:0]  rs2i,
    output logic        stall_out,
    output logic        valid_out,
    output logic [31:0] pc_out,
    output logic [4:0]  rd_out,
    output logic [31:0] imm_out,
    output logic [4:0]  alu_op_out,
    output logic        reg_write_out,
    output logic        mem_read_out,
    output logic        mem_write_out,
    output logic        branch_out,
    output logic        jump_out,
    output logic        illegal_out
);

    import cpu_pkg::*;

    id_ex_t      q;
    id_ex_t      dec;
    fmt_e        fmt;
    logic [31:0] imm;
    logic [31:0] dinst;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        has_rd;
    logic        ill;
    logic        use1;
    logic        use2;
    logic        haz;
    logic        bubble;

    assign rs1i = inst[19:15];
    assign rs2i = inst[24:20];

    // Which source registers the fetched instruction really reads
    always_comb begin
        use1 = 1'b0;
        use2 = 1'b0;
        unique case (inst[6:0])
            OPC_JALR, OPC_LOAD, OPC_OPIMM: use1 = 1'b1;
            OPC_BRANCH, OPC_STORE, OPC_OP: begin
                use1 = 1'b1;
                use2 = 1'b1;
            end
            default: ;
        endcase
    end

    assign haz = q.valid & q.mem_read & (q.rd != 5'd0) & inst_valid &
                 ((use1 & (q.rd == inst[19:15])) |
                  (use2 & (q.rd == inst[24:20])));

    assign stall_out = ~flush & (stall_in | haz);
    assign bubble    = flush | haz | ~inst_valid;
    assign dinst     = bubble ? NOP_INST : inst;
    assign opc       = dinst[6:0];
    assign f3        = dinst[14:12];
    assign f7        = dinst[31:25];

    imm_gen u_imm_gen (
        .inst (dinst),
        .fmt  (fmt),
        .imm  (imm)
    );

    // Decode the selected word (real instruction or bubble) into controls
    always_comb begin
        dec        = '0;
        fmt        = FMT_R;
        has_rd     = 1'b0;
        ill        = 1'b0;
        dec.alu_op = ALU_ADD;
        unique case (opc)
            OPC_LUI: begin
                fmt        = FMT_U;
                has_rd     = 1'b1;
                dec.alu_op = ALU_PASSB;
            end
            OPC_AUIPC: begin
                fmt    = FMT_U;
                has_rd = 1'b1;
            end
            OPC_JAL: begin
                fmt      = FMT_J;
                has_rd   = 1'b1;
                dec.jump = 1'b1;
            end
            OPC_JALR: begin
                fmt      = FMT_I;
                has_rd   = 1'b1;
                dec.jump = 1'b1;
                ill      = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                fmt        = FMT_B;
                dec.branch = 1'b1;
                unique case (f3)
                    3'b000, 3'b001: dec.alu_op = ALU_SUB;
                    3'b100, 3'b101: dec.alu_op = ALU_SLT;
                    3'b110, 3'b111: dec.alu_op = ALU_SLTU;
                    default:        ill = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                fmt          = FMT_I;
                has_rd       = 1'b1;
                dec.mem_read = 1'b1;
                ill = (f3 == 3'b011) | (f3 == 3'b110) | (f3 == 3'b111);
            end
            OPC_STORE: begin
                fmt           = FMT_S;
                dec.mem_write = 1'b1;
                ill = (f3 > 3'b010);
            end
            OPC_OPIMM: begin
                fmt    = FMT_I;
                has_rd = 1'b1;
                unique case (f3)
                    3'b000: dec.alu_op = ALU_ADD;
                    3'b010: dec.alu_op = ALU_SLT;
                    3'b011: dec.alu_op = ALU_SLTU;
                    3'b100: dec.alu_op = ALU_XOR;
                    3'b110: dec.alu_op = ALU_OR;
                    3'b111: dec.alu_op = ALU_AND;
                    3'b001: begin
                        dec.alu_op = ALU_SLL;
                        ill        = (f7 != 7'h00);
                    end
                    default: begin
                        dec.alu_op = (f7 == 7'h20) ? ALU_SRA : ALU_SRL;
                        ill        = (f7 != 7'h00) & (f7 != 7'h20);
                    end
                endcase
            end
            OPC_OP: begin
                fmt    = FMT_R;
                has_rd = 1'b1;
                unique case ({f7, f3})
                    {7'h00, 3'b000}: dec.alu_op = ALU_ADD;
                    {7'h20, 3'b000}: dec.alu_op = ALU_SUB;
                    {7'h00, 3'b001}: dec.alu_op = ALU_SLL;
                    {7'h00, 3'b010}: dec.alu_op = ALU_SLT;
                    {7'h00, 3'b011}: dec.alu_op = ALU_SLTU;
                    {7'h00, 3'b100}: dec.alu_op = ALU_XOR;
                    {7'h00, 3'b101}: dec.alu_op = ALU_SRL;
                    {7'h20, 3'b101}: dec.alu_op = ALU_SRA;
                    {7'h00, 3'b110}: dec.alu_op = ALU_OR;
                    {7'h00, 3'b111}: dec.alu_op = ALU_AND;
`ifdef DECODE_RV32M_EN
                    {7'h01, 3'b000}: dec.alu_op = ALU_MUL;
                    {7'h01, 3'b001}: dec.alu_op = ALU_MULH;
                    {7'h01, 3'b010}: dec.alu_op = ALU_MULHSU;
                    {7'h01, 3'b011}: dec.alu_op = ALU_MULHU;
                    {7'h01, 3'b100}: dec.alu_op = ALU_DIV;
                    {7'h01, 3'b101}: dec.alu_op = ALU_DIVU;
                    {7'h01, 3'b110}: dec.alu_op = ALU_REM;
                    {7'h01, 3'b111}: dec.alu_op = ALU_REMU;
`endif
                    default: ill = 1'b1;
                endcase
            end
            OPC_FENCE, OPC_SYSTEM: ;
            default: ill = 1'b1;
        endcase

        if (ill) begin
            has_rd        = 1'b0;
            fmt           = FMT_R;
            dec.alu_op    = ALU_ADD;
            dec.mem_read  = 1'b0;
            dec.mem_write = 1'b0;
            dec.branch    = 1'b0;
            dec.jump      = 1'b0;
        end

        dec.valid     = ~bubble;
        dec.pc        = bubble ? 32'd0 : pc_in;
        dec.rd        = has_rd ? dinst[11:7] : 5'd0;
        dec.imm       = imm;
        dec.reg_write = has_rd & (dinst[11:7] != 5'd0);
        dec.illegal   = ill;
    end

    // Output register: flush always loads, stall_in otherwise holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (flush || !stall_in) begin
            q <= dec;
        end
    end

    assign valid_out     = q.valid;
    assign pc_out        = q.pc;
    assign rd_out        = q.rd;
    assign imm_out       = q.imm;
    assign alu_op_out    = q.alu_op;
    assign reg_write_out = q.reg_write;
    assign mem_read_out  = q.mem_read;
    assign mem_write_out = q.mem_write;
    assign branch_out    = q.branch;
    assign jump_out      = q.jump;
    assign illegal_out   = q.illegal;

endmodule
